// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite configuration master: walks a WRITE/POLL/END command table on start.
// Optional watchdog on bus waits when CFG_SEQ_WDOG_EN is defined.
module axil_cfg_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned IDX_W    = 6,
   parameter int unsigned POLL_MAX = 1024,
   localparam int unsigned CMD_W   = 2 + ADDR_W + 2 * DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [IDX_W-1:0]    cmd_idx,
   input  logic [CMD_W-1:0]    cmd_word,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready
);

   localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);

   typedef enum logic [1:0] {
      OpEnd   = 2'b00,
      OpWrite = 2'b01,
      OpPoll  = 2'b10,
      OpRsvd  = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      StIdle, StFetch, StAwW, StB, StAr, StR, StNext, StFin, StErr
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                err_q, err_d;
   logic                aw_pend_q, aw_pend_d;
   logic                w_pend_q, w_pend_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   mask_q, mask_d;
   logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;

   op_e                 c_op;
   logic [ADDR_W-1:0]   c_addr;
   logic [DATA_W-1:0]   c_data;
   logic [DATA_W-1:0]   c_mask;

   assign c_op   = op_e'(cmd_word[CMD_W-1 -: 2]);
   assign c_addr = cmd_word[2*DATA_W +: ADDR_W];
   assign c_data = cmd_word[DATA_W +: DATA_W];
   assign c_mask = cmd_word[DATA_W-1:0];

`ifdef CFG_SEQ_WDOG_EN
   logic [15:0] wdog_q, wdog_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         err_q      <= 1'b0;
         aw_pend_q  <= 1'b0;
         w_pend_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         poll_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         aw_pend_q  <= aw_pend_d;
         w_pend_q   <= w_pend_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         poll_cnt_q <= poll_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      err_d      = err_q;
      aw_pend_d  = aw_pend_q;
      w_pend_d   = w_pend_q;
      addr_d     = addr_q;
      data_d     = data_q;
      mask_d     = mask_q;
      poll_cnt_d = poll_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         StFetch: begin
            addr_d = c_addr;
            data_d = c_data;
            mask_d = c_mask;
            unique case (c_op)
               OpWrite: begin
                  state_d   = StAwW;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
               end
               OpPoll: begin
                  state_d    = StAr;
                  poll_cnt_d = '0;
               end
               OpEnd:   state_d = StFin;
               default: state_d = StErr;
            endcase
         end
         StAwW: begin
            // AW and W complete independently; leave only once both have.
            if (aw_pend_q && awready) aw_pend_d = 1'b0;
            if (w_pend_q && wready)   w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d) state_d = StB;
         end
         StB: begin
            if (bvalid) state_d = (bresp != 2'b00) ? StErr : StNext;
         end
         StAr: begin
            if (arready) state_d = StR;
         end
         StR: begin
            if (rvalid) begin
               if (rresp != 2'b00) begin
                  state_d = StErr;
               end else if (((rdata ^ data_q) & mask_q) == '0) begin
                  state_d = StNext;
               end else begin
                  poll_cnt_d = poll_cnt_q + PCNT_W'(1);
                  state_d    = (poll_cnt_d == PCNT_W'(POLL_MAX)) ? StErr : StAr;
               end
            end
         end
         StNext: begin
            if (idx_q == '1) begin
               state_d = StFin;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = StFetch;
            end
         end
         StFin:   state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

`ifdef CFG_SEQ_WDOG_EN
      if (wdog_q == 16'hFFFF) state_d = StErr;
`endif

      if (state_d == StErr) begin
         err_d     = 1'b1;
         aw_pend_d = 1'b0;
         w_pend_d  = 1'b0;
      end
   end

`ifdef CFG_SEQ_WDOG_EN
   // Only the bus-wait states accumulate; any state change restarts the count.
   always_comb begin
      wdog_d = '0;
      if (state_d == state_q && (state_q inside {StAwW, StB, StAr, StR})) begin
         wdog_d = wdog_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end
`endif

   assign busy    = state_q inside {StFetch, StAwW, StB, StAr, StR, StNext};
   assign done    = (state_q == StFin);
   assign err     = err_q;
   assign cmd_idx = idx_q;
   assign awaddr  = addr_q;
   assign araddr  = addr_q;
   assign wdata   = data_q;
   assign wstrb   = '1;
   assign awvalid = aw_pend_q;
   assign wvalid  = w_pend_q;
   assign bready  = (state_q == StB);
   assign arvalid = (state_q == StAr);
   assign rready  = (state_q == StR);

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Bench for axil_cfg_sequencer: vector table, hand-written corner cases and
// randomized tables checked against a table-walking reference model.
module tb_axil_cfg_sequencer;

   localparam int ADDR_W = 8, DATA_W = 32, IDX_W = 6, POLL_MAX = 4;
   localparam int CMD_W = 2 + ADDR_W + 2 * DATA_W;
   localparam int DEPTH = 1 << IDX_W;

   logic clk = 0, rst = 1, start = 0;
   logic busy, done, err;
   logic [IDX_W-1:0] cmd_idx;
   logic [CMD_W-1:0] cmd_word;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [DATA_W-1:0] wdata, rdata = '0;
   logic [DATA_W/8-1:0] wstrb;
   logic awvalid, wvalid, bready, arvalid, rready;
   logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
   logic [1:0] bresp = 0, rresp = 0;

   always #5 clk = ~clk;

   axil_cfg_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W),
                        .POLL_MAX(POLL_MAX)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .cmd_idx(cmd_idx), .cmd_word(cmd_word),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready));

   logic [CMD_W-1:0] tbl [DEPTH];
   assign cmd_word = tbl[cmd_idx];

   // Slave behaviour and response data
   int dly_aw, dly_w, dly_b, dly_ar, dly_r;
   int c_aw, c_w, c_b, c_ar, c_r;
   bit rand_dly;
   logic [31:0] rd_vals [256];
   logic [1:0]  rresp_vals [256];
   logic [1:0]  bresp_vals [DEPTH];
   int rd_i, b_i;

   // Observed traffic
   logic [7:0]  aw_q[$], ar_q[$];
   logic [31:0] w_q[$];
   int n_b, n_r;

   // Expected results
   logic [7:0]  exp_wa[$];
   logic [31:0] exp_wd[$];
   bit exp_done;
   int exp_idx, exp_nrd;

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [CMD_W-1:0] mk(input logic [1:0] op, input logic [7:0] a,
                                           input logic [31:0] d, input logic [31:0] m);
      return {op, a, d, m};
   endfunction

   function automatic int nd(input int cur);
      return rand_dly ? int'($urandom_range(0, 3)) : cur;
   endfunction

   // Slave drives its inputs shortly after each rising edge.
   task automatic slave_step();
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      if (awvalid) begin
         if (c_aw >= dly_aw) begin awready = 1; c_aw = 0; dly_aw = nd(dly_aw); end
         else c_aw++;
      end
      if (wvalid) begin
         if (c_w >= dly_w) begin wready = 1; c_w = 0; dly_w = nd(dly_w); end
         else c_w++;
      end
      if (bready) begin
         if (c_b >= dly_b) begin
            bvalid = 1; bresp = bresp_vals[b_i % DEPTH]; b_i++;
            c_b = 0; dly_b = nd(dly_b);
         end else c_b++;
      end
      if (arvalid) begin
         if (c_ar >= dly_ar) begin arready = 1; c_ar = 0; dly_ar = nd(dly_ar); end
         else c_ar++;
      end
      if (rready) begin
         if (c_r >= dly_r) begin
            rvalid = 1; rdata = rd_vals[rd_i % 256]; rresp = rresp_vals[rd_i % 256]; rd_i++;
            c_r = 0; dly_r = nd(dly_r);
         end else c_r++;
      end
   endtask

   initial forever begin
      @(posedge clk);
      #2;
      slave_step();
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (awvalid && awready) aw_q.push_back(awaddr);
         if (wvalid && wready)   w_q.push_back(wdata);
         if (arvalid && arready) ar_q.push_back(araddr);
         if (bvalid && bready)   n_b++;
         if (rvalid && rready)   n_r++;
      end
   end

   task automatic clr(input bit rnd, input int d);
      aw_q.delete(); w_q.delete(); ar_q.delete();
      n_b = 0; n_r = 0; rd_i = 0; b_i = 0;
      c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
      rand_dly = rnd;
      dly_aw = d; dly_w = d; dly_b = d; dly_ar = d; dly_r = d;
   endtask

   task automatic fill(input logic [31:0] rdv, input logic [1:0] rr, input logic [1:0] br);
      for (int i = 0; i < DEPTH; i++) begin
         tbl[i] = mk(2'b00, 8'h0, 32'h0, 32'h0);
         bresp_vals[i] = br;
      end
      for (int i = 0; i < 256; i++) begin
         rd_vals[i] = rdv;
         rresp_vals[i] = rr;
      end
   endtask

   task automatic kick();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   // Runs from cycle `cyc` until done or err; cyc_end is the cycle it was seen.
   task automatic wait_end(input string tag, input int cyc, input int budget,
                           output int cyc_end, output bit saw_done);
      while (!(done || err) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      cyc_end = cyc;
      saw_done = done;
      chk({tag, ".finish"}, done | err, 1);
      if (!(done || err)) begin
         rst = 1; repeat (2) @(negedge clk); rst = 0;
      end else begin
         @(negedge clk);
         chk({tag, ".pulse"}, {done, busy}, 2'b00);
      end
   endtask

   task automatic run(input string tag, input int budget, output int cyc_end,
                      output bit saw_done);
      kick();
      chk({tag, ".busy1"}, {busy, err}, 2'b10);
      wait_end(tag, 1, budget, cyc_end, saw_done);
   endtask

   // Walks the table by the command rules, consuming slave responses in order.
   task automatic model();
      int idx = 0, rd = 0, wr = 0;
      bit stop = 0, hit;
      logic [CMD_W-1:0] e;
      logic [1:0] op;
      logic [7:0] a;
      logic [31:0] d, m;
      exp_wa.delete(); exp_wd.delete();
      exp_done = 0;
      while (!stop) begin
         e = tbl[idx];
         {op, a, d, m} = e;
         if (op == 2'b00) begin
            exp_done = 1; stop = 1;
         end else if (op == 2'b01) begin
            exp_wa.push_back(a); exp_wd.push_back(d);
            if (bresp_vals[wr] != 0) stop = 1;
            wr++;
         end else if (op == 2'b10) begin
            hit = 0;
            for (int n = 0; n < POLL_MAX && !hit && !stop; n++) begin
               if (rresp_vals[rd] != 0) stop = 1;
               else if ((rd_vals[rd] & m) == (d & m)) hit = 1;
               rd++;
            end
            if (!hit) stop = 1;
         end else begin
            stop = 1;
         end
         if (!stop) begin
            if (idx == DEPTH - 1) begin exp_done = 1; stop = 1; end
            else idx++;
         end
      end
      exp_idx = idx;
      exp_nrd = rd;
   endtask

   task automatic check_model(input string tag, input bit saw_done);
      chk({tag, ".done"}, saw_done, exp_done);
      chk({tag, ".err"}, err, !exp_done);
      chk({tag, ".idx"}, cmd_idx, exp_idx);
      chk({tag, ".nwr"}, aw_q.size(), exp_wa.size());
      chk({tag, ".nw"}, w_q.size(), exp_wd.size());
      chk({tag, ".nb"}, n_b, exp_wa.size());
      chk({tag, ".nrd"}, n_r, exp_nrd);
      for (int i = 0; i < aw_q.size() && i < exp_wa.size(); i++)
         chk($sformatf("%s.awaddr%0d", tag, i), aw_q[i], exp_wa[i]);
      for (int i = 0; i < w_q.size() && i < exp_wd.size(); i++)
         chk($sformatf("%s.wdata%0d", tag, i), w_q[i], exp_wd[i]);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [31:0] data, mask, rdv;
      logic [1:0]  bresp, rresp;
      bit          exp_done;
      int          exp_cyc, exp_nwr, exp_nrd, exp_idx;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int cyc_end, k;
      bit sd;
      logic [31:0] dv;

      vecs[0] = '{2'b00, 8'h00, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1, 2, 0, 0, 0};
      vecs[1] = '{2'b01, 8'h10, 32'hA5A5A5A5, 32'h0, 32'h0, 2'd0, 2'd0, 1, 6, 1, 0, 1};
      vecs[2] = '{2'b01, 8'h20, 32'h12345678, 32'h0, 32'h0, 2'd2, 2'd0, 0, 4, 1, 0, 0};
      vecs[3] = '{2'b11, 8'h30, 32'h1, 32'h1, 32'h0, 2'd0, 2'd0, 0, 2, 0, 0, 0};
      vecs[4] = '{2'b10, 8'h04, 32'h1, 32'h1, 32'h1, 2'd0, 2'd0, 1, 6, 0, 1, 1};
      vecs[5] = '{2'b10, 8'h08, 32'hFFFF0005, 32'hF, 32'h12345675, 2'd0, 2'd0, 1, 6, 0, 1, 1};
      vecs[6] = '{2'b10, 8'h04, 32'h1, 32'h1, 32'h0, 2'd0, 2'd0, 0, 10, 0, 4, 0};
      vecs[7] = '{2'b10, 8'h0C, 32'h1, 32'h1, 32'h1, 2'd0, 2'd2, 0, 4, 0, 1, 0};
      vecs[8] = '{2'b01, 8'h44, 32'hCAFEF00D, 32'h0, 32'h0, 2'd1, 2'd0, 0, 4, 1, 0, 0};

      fill(0, 0, 0);
      clr(0, 0);
      repeat (3) @(negedge clk);
      chk("rst.ctrl", {busy, done, err, cmd_idx}, 0);
      chk("rst.valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      chk("rst.bus", {awaddr, araddr, wdata}, 0);
      chk("rst.wstrb", wstrb, 4'hF);
      rst = 0;
      @(negedge clk);

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         fill(vecs[i].rdv, vecs[i].rresp, vecs[i].bresp);
         tbl[0] = mk(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask);
         clr(0, 0);
         run(tag, 200, cyc_end, sd);
         chk({tag, ".done"}, sd, vecs[i].exp_done);
         chk({tag, ".err"}, err, !vecs[i].exp_done);
         chk({tag, ".cyc"}, cyc_end, vecs[i].exp_cyc);
         chk({tag, ".nwr"}, aw_q.size(), vecs[i].exp_nwr);
         chk({tag, ".nrd"}, ar_q.size(), vecs[i].exp_nrd);
         chk({tag, ".idx"}, cmd_idx, vecs[i].exp_idx);
         if (vecs[i].exp_nwr > 0 && aw_q.size() > 0 && w_q.size() > 0)
            chk({tag, ".aw_w"}, {aw_q[0], w_q[0]}, {vecs[i].addr, vecs[i].data});
         if (vecs[i].exp_nrd > 0 && ar_q.size() > 0)
            chk({tag, ".araddr"}, ar_q[0], vecs[i].addr);
      end

      // awready held off 3 cycles past wready
      fill(0, 0, 0);
      tbl[0] = mk(2'b01, 8'h10, 32'hA5A5A5A5, 32'h0);
      clr(0, 0);
      dly_aw = 3;
      kick();
      @(negedge clk);
      chk("slow_aw.c2", {awvalid, wvalid, awaddr, wdata}, {2'b11, 8'h10, 32'hA5A5A5A5});
      @(negedge clk);
      chk("slow_aw.c3", {awvalid, wvalid}, 2'b10);
      wait_end("slow_aw", 3, 200, cyc_end, sd);
      chk("slow_aw.done", {sd, err}, 2'b10);
      chk("slow_aw.nb", n_b, 1);
      chk("slow_aw.naw", {aw_q.size() == 1, w_q.size() == 1}, 2'b11);

      // poll answers 0,0,1
      fill(0, 0, 0);
      rd_vals[2] = 32'h1;
      tbl[0] = mk(2'b10, 8'h04, 32'h1, 32'h1);
      clr(0, 0);
      run("poll001", 200, cyc_end, sd);
      chk("poll001.done", {sd, err}, 2'b10);
      chk("poll001.nrd", ar_q.size(), 3);
      chk("poll001.cyc", cyc_end, 10);
      foreach (ar_q[i]) chk($sformatf("poll001.araddr%0d", i), ar_q[i], 8'h04);

      // poll timeout, sticky err, then cleared by next start
      tbl[0] = mk(2'b10, 8'h04, 32'h1, 32'h1);
      rd_vals[2] = 32'h0;
      clr(0, 0);
      run("ptmo", 200, cyc_end, sd);
      chk("ptmo.res", {sd, err, cmd_idx}, {2'b01, 6'd0});
      chk("ptmo.nrd", ar_q.size(), POLL_MAX);
      repeat (3) @(negedge clk);
      chk("ptmo.sticky", err, 1);
      fill(0, 0, 0);
      clr(0, 0);
      run("ptmo_restart", 200, cyc_end, sd);
      chk("ptmo_restart.done", {sd, err}, 2'b10);

      // reset while a write is outstanding
      fill(0, 0, 0);
      tbl[0] = mk(2'b01, 8'h55, 32'h1, 32'h0);
      clr(0, 20);
      kick();
      @(negedge clk);
      chk("rst_mid.pre", {awvalid, wvalid, busy}, 3'b111);
      rst = 1;
      @(negedge clk);
      chk("rst_mid.post", {awvalid, wvalid, busy, done, cmd_idx}, 0);
      rst = 0;
      @(negedge clk);
      chk("rst_mid.nohs", aw_q.size() + w_q.size() + n_b, 0);

      // start while busy must be ignored
      fill(0, 0, 0);
      tbl[0] = mk(2'b01, 8'h01, 32'h11, 32'h0);
      tbl[1] = mk(2'b01, 8'h02, 32'h22, 32'h0);
      clr(0, 6);
      kick();
      k = 0;
      while (!(cmd_idx == 1 && awvalid) && k < 100) begin @(negedge clk); k++; end
      chk("busy_start.reach", {cmd_idx, awvalid}, {6'd1, 1'b1});
      start = 1;
      @(negedge clk);
      start = 0;
      chk("busy_start.hold", {cmd_idx, awvalid, busy}, {6'd1, 2'b11});
      wait_end("busy_start", 1, 300, cyc_end, sd);
      chk("busy_start.res", {sd, err, cmd_idx}, {2'b10, 6'd2});
      chk("busy_start.nwr", aw_q.size(), 2);

      // full table of writes: implicit end at the last index
      fill(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) tbl[i] = mk(2'b01, 8'(i), $urandom, 32'h0);
      clr(1, 0);
      model();
      run("full", 5000, cyc_end, sd);
      check_model("full", sd);

      // randomized tables
      for (int t = 0; t < 25; t++) begin
         int len;
         fill(0, 0, 0);
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            int r;
            r = $urandom_range(0, 19);
            dv = $urandom;
            if (r < 10)      tbl[i] = mk(2'b01, 8'($urandom), dv, 32'h0);
            else if (r < 19) tbl[i] = mk(2'b10, 8'($urandom), dv,
                                         32'h3 << (2 * $urandom_range(0, 15)));
            else             tbl[i] = mk(2'b11, 8'($urandom), dv, 32'h0);
         end
         for (int i = 0; i < DEPTH; i++) bresp_vals[i] = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0;
         for (int i = 0; i < 256; i++) begin
            rd_vals[i] = $urandom;
            rresp_vals[i] = ($urandom_range(0, 19) == 0) ? 2'd2 : 2'd0;
         end
         clr(1, $urandom_range(0, 3));
         model();
         run($sformatf("rnd%0d", t), 2000, cyc_end, sd);
         check_model($sformatf("rnd%0d", t), sd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axil_cfg_sequencer.md
Name:
axil_cfg_sequencer

Overview:
AXI4-Lite master that configures a peripheral (DMA core, codec registers) by walking a command table on `start`. Each table entry is a register write, a read-poll, or end-of-list. It replaces testbench-driven register programming in the integrated design. The block owns the single AXI-Lite master port and keeps at most one transaction outstanding.

Parameters:
ADDR_W, 8, AXI-Lite address width
DATA_W, 32, AXI-Lite data width
IDX_W, 6, command table index width; table depth = 2**IDX_W
POLL_MAX, 1024, poll reads per POLL command before timeout error (>=1)
CMD_W, 2+ADDR_W+2*DATA_W, command word width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin sequence at index 0; ignored while busy
busy  out  1  high from the cycle after accepted start until the done/err cycle
done  out  1  one-cycle pulse: sequence completed without error
err  out  1  sticky error flag, cleared by the next accepted start
cmd_idx  out  IDX_W  table read index (registered)
cmd_word  in  CMD_W  {op[1:0], addr, data, mask}; combinational table read of cmd_idx
awaddr  out  ADDR_W  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  DATA_W  write data
wstrb  out  DATA_W/8  always all ones
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready
araddr  out  ADDR_W  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  DATA_W  read data
rresp  in  2  read response
rvalid  in  1  read valid
rready  out  1  read ready

Behaviour:
- Reset: state IDLE. busy, done, err, cmd_idx, awvalid, wvalid, bready, arvalid, rready all 0. awaddr, wdata, araddr 0. Reset mid-transaction drops all valids on the next edge with no completion.
- Ops: 00 END, 01 WRITE, 10 POLL, 11 reserved (err set, sequence stops, no bus activity).
- FSM: IDLE -> FETCH on start (cmd_idx <= 0, err <= 0).
- FETCH (1 cycle): latch addr/data/mask from cmd_word, then branch: WRITE -> AW_W; POLL -> AR with poll count 0; END -> FIN.
- AW_W: awvalid and wvalid assert together. Each valid drops on the cycle after its own handshake, independently. When both handshakes have occurred (same or different cycles) -> B.
- B: bready=1. On bvalid: bresp!=0 -> ERR, else -> NEXT.
- AR: arvalid=1 until arready -> R.
- R: rready=1. On rvalid:
  - rresp!=0 -> ERR.
  - (rdata&mask)==(data&mask) -> NEXT.
  - Otherwise poll count++. If count reaches POLL_MAX -> ERR, else -> AR (new read).
- NEXT: if cmd_idx == 2**IDX_W-1 -> FIN (implicit end, no wrap). Otherwise cmd_idx++ -> FETCH.
- FIN: done=1 for one cycle, busy drops -> IDLE.
- ERR: err=1 (sticky), busy drops, no done pulse -> IDLE.
- Valids never drop before their handshake. Address/data stay stable while valid is high.
- Latency with always-ready slave (awready=wready=bvalid=1 combinationally):
  - start@T -> awvalid@T+2, bready@T+3.
  - Each WRITE takes 4 cycles (FETCH, AW_W, B, NEXT).
  - END-only table: done@T+2.

Optional Feature:
Macro CFG_SEQ_WDOG_EN.
- Defined: a 16-bit counter, cleared on every state change, counts cycles in AW_W, B, AR and R. Reaching 0xFFFF -> ERR; valids drop.
- Undefined: no counter; the block waits indefinitely for handshakes.

Test Plan:
- Table [WR 0x10<-0xA5A5A5A5, END], slave always ready, bresp=0 -> one AW/W beat with awaddr=0x10, wdata=0xA5A5A5A5; done pulses at start+6; err=0.
- Same WRITE with awready delayed 3 cycles after wready -> wvalid drops after its handshake, awvalid held; exactly one B accepted; done pulses.
- POLL addr 0x04, data 0x1, mask 0x1; rdata returns 0,0,1 -> three AR handshakes, then NEXT; done pulses.
- POLL_MAX=4, rdata always 0 -> exactly 4 reads, err=1, no done; a subsequent start clears err.
- WRITE with bresp=2'b10 -> err=1, next table entry never fetched (cmd_idx unchanged); op=11 entry -> err with no AW/AR activity.
- rst asserted while awvalid=1 -> next cycle awvalid=wvalid=busy=0; start while busy has no effect on cmd_idx.
